// File: rtl/up_pkg.sv
// ---------------------------------------------------------------------------
// up_pkg : shared definitions for the 4-bit microprocessor.
//   DATA_W    : data path width (4)
//   alu_op_e  : opALU encodings, ALU_PASSB .. ALU_NOTA
//   bus_src_e : which source currently owns the data bus
// ---------------------------------------------------------------------------
package up_pkg;

   localparam int DATA_W = 4;

   typedef enum logic [2:0] {
      ALU_PASSB = 3'b000,
      ALU_ADD   = 3'b001,
      ALU_SUB   = 3'b010,
      ALU_AND   = 3'b011,
      ALU_OR    = 3'b100,
      ALU_XOR   = 3'b101,
      ALU_NAND  = 3'b110,
      ALU_NOTA  = 3'b111
   } alu_op_e;

   typedef enum logic [2:0] {
      BUS_NONE  = 3'd0,
      BUS_ACCU  = 3'd1,
      BUS_IN    = 3'd2,
      BUS_OPRND = 3'd3,
      BUS_RAM   = 3'd4
   } bus_src_e;

endpackage : up_pkg

// File: rtl/alu_4b.sv
// ---------------------------------------------------------------------------
// alu_4b : combinational 4-bit ALU.
//   opALU  in  3  operation select (alu_op_e encoding)
//   A      in  4  first operand (accumulator)
//   B      in  4  second operand (data bus)
//   result out 4  operation result
//   carry  out 1  bit 4 of the sum for ADD/SUB, 0 for logic ops
//   zero   out 1  result == 0
// ---------------------------------------------------------------------------
module alu_4b
   import up_pkg::*;
(
   input  logic [2:0]        opALU,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              zero
);

   logic [DATA_W:0] w_sum;

   // NOTE: every signal written in always_comb gets a default first, so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      w_sum  = '0;
      result = '0;
      carry  = 1'b0;
      case (alu_op_e'(opALU))
         ALU_PASSB: result = B;
         ALU_ADD: begin
            w_sum  = {1'b0, A} + {1'b0, B};
            result = w_sum[DATA_W-1:0];
            carry  = w_sum[DATA_W];
         end
         // Two's-complement subtract: carry out = 1 means no borrow (A >= B).
         ALU_SUB: begin
            w_sum  = {1'b0, A} + {1'b0, ~B} + {{DATA_W{1'b0}}, 1'b1};
            result = w_sum[DATA_W-1:0];
            carry  = w_sum[DATA_W];
         end
         ALU_AND:  result = A & B;
         ALU_OR:   result = A | B;
         ALU_XOR:  result = A ^ B;
         ALU_NAND: result = ~(A & B);
         ALU_NOTA: result = ~A;
         default:  result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule : alu_4b

// File: rtl/execute_unit.sv
// ---------------------------------------------------------------------------
// execute_unit : execution datapath of the 4-bit microprocessor.
// Owns the data bus mux, ALU, accumulator, carry/zero flags, data RAM,
// output latch and the two-flop pushbutton synchronizer.
//   clock        in   1  rising-edge clock
//   reset        in   1  asynchronous active-low; clears all regs except RAM
//   loadA        in   1  accumulator <= ALU result
//   loadFlags    in   1  c_flag/z_flag <= ALU carry/zero
//   opALU        in   3  ALU operation
//   cs, we       in   1  RAM chip select / write enable (write = cs & we)
//   eoALU        in   1  accumulator drives the bus
//   oeIn         in   1  synchronized pushbuttons drive the bus
//   oeOprnd      in   1  immediate operand drives the bus
//   loadOut      in   1  FF_out <= data_bus
//   oprnd        in   4  immediate operand
//   address_RAM  in  12  RAM address, low RAM_AW bits used
//   pushbuttons  in   4  asynchronous external inputs
//   data_bus     out  4  resolved bus value
//   accu         out  4  accumulator
//   FF_out       out  4  output latch
//   c_flag       out  1  carry flag
//   z_flag       out  1  zero flag
//   bus_conflict out  1  two or more bus sources enabled
// ---------------------------------------------------------------------------
module execute_unit
   import up_pkg::*;
#(
   parameter int RAM_AW = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              loadA,
   input  logic              loadFlags,
   input  logic [2:0]        opALU,
   input  logic              cs,
   input  logic              we,
   input  logic              eoALU,
   input  logic              oeIn,
   input  logic              oeOprnd,
   input  logic              loadOut,
   input  logic [DATA_W-1:0] oprnd,
   input  logic [11:0]       address_RAM,
   input  logic [DATA_W-1:0] pushbuttons,
   output logic [DATA_W-1:0] data_bus,
   output logic [DATA_W-1:0] accu,
   output logic [DATA_W-1:0] FF_out,
   output logic              c_flag,
   output logic              z_flag,
   output logic              bus_conflict
);

   logic [DATA_W-1:0] r_accu;
   logic [DATA_W-1:0] r_ff_out;
   logic              r_c_flag;
   logic              r_z_flag;
   logic [DATA_W-1:0] r_sync_s1;
   logic [DATA_W-1:0] r_sync_in;
   logic [DATA_W-1:0] r_ram [0:(2**RAM_AW)-1];

   logic [RAM_AW-1:0] w_addr;
   logic              w_unused_addr;
   logic              w_ram_rd;
   logic              w_ram_wr;
   logic [DATA_W-1:0] w_ram_q;
   logic [2:0]        w_src_cnt;
   bus_src_e          w_bus_src;
   logic [DATA_W-1:0] w_alu_result;
   logic              w_alu_carry;
   logic              w_alu_zero;

   // Upper address bits are dropped on purpose: addresses alias modulo depth.
   assign w_addr        = address_RAM[RAM_AW-1:0];
   assign w_unused_addr = ^address_RAM[11:RAM_AW];

   assign w_ram_rd = cs & ~we;
   assign w_ram_wr = cs & we & reset;
   assign w_ram_q  = r_ram[w_addr];

   // Bus mux in fixed priority; conflicts are flagged but still resolved.
   always_comb begin
      w_bus_src = BUS_NONE;
      if (eoALU)         w_bus_src = BUS_ACCU;
      else if (oeIn)     w_bus_src = BUS_IN;
      else if (oeOprnd)  w_bus_src = BUS_OPRND;
      else if (w_ram_rd) w_bus_src = BUS_RAM;
   end

   always_comb begin
      data_bus = '0;
      case (w_bus_src)
         BUS_ACCU:  data_bus = r_accu;
         BUS_IN:    data_bus = r_sync_in;
         BUS_OPRND: data_bus = oprnd;
         BUS_RAM:   data_bus = w_ram_q;
         default:   data_bus = '0;
      endcase
   end

   assign w_src_cnt    = 3'(eoALU) + 3'(oeIn) + 3'(oeOprnd) + 3'(w_ram_rd);
   assign bus_conflict = (w_src_cnt >= 3'd2);

   alu_4b u_alu (
      .opALU  (opALU),
      .A      (r_accu),
      .B      (data_bus),
      .result (w_alu_result),
      .carry  (w_alu_carry),
      .zero   (w_alu_zero)
   );

   // NOTE: state registers use non-blocking assignments so every register
   // samples the same pre-edge bus/ALU values (store + loadA in one cycle
   // writes the old accumulator to RAM).
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_accu    <= '0;
         r_ff_out  <= '0;
         r_c_flag  <= 1'b0;
         r_z_flag  <= 1'b0;
         r_sync_s1 <= '0;
         r_sync_in <= '0;
      end else begin
         r_sync_s1 <= pushbuttons;
         r_sync_in <= r_sync_s1;
         if (loadA)   r_accu   <= w_alu_result;
         if (loadOut) r_ff_out <= data_bus;
         if (loadFlags) begin
            r_c_flag <= w_alu_carry;
            r_z_flag <= w_alu_zero;
         end
      end
   end

   // NOTE: the RAM array has no reset (contents are undefined at power-up);
   // reset only gates the write enable so a held reset cannot corrupt it.
   always_ff @(posedge clock) begin
      if (w_ram_wr) r_ram[w_addr] <= data_bus;
   end

   assign accu   = r_accu;
   assign FF_out = r_ff_out;
   assign c_flag = r_c_flag;
   assign z_flag = r_z_flag;

endmodule : execute_unit

// File: tb/tb_execute_unit.sv
// ---------------------------------------------------------------------------
// tb_execute_unit : directed self-checking bench for execute_unit.
// Inputs change #1 after a rising edge; outputs are sampled mid-cycle.
// ---------------------------------------------------------------------------
module tb_execute_unit;
   import up_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        loadA, loadFlags, cs, we, eoALU, oeIn, oeOprnd, loadOut;
   logic [2:0]  opALU;
   logic [3:0]  oprnd, pushbuttons;
   logic [11:0] address_RAM;
   logic [3:0]  data_bus, accu, FF_out;
   logic        c_flag, z_flag, bus_conflict;

   int n_checks = 0;
   int n_errors = 0;

   execute_unit #(.RAM_AW(8)) dut (
      .clock        (clock),
      .reset        (reset),
      .loadA        (loadA),
      .loadFlags    (loadFlags),
      .opALU        (opALU),
      .cs           (cs),
      .we           (we),
      .eoALU        (eoALU),
      .oeIn         (oeIn),
      .oeOprnd      (oeOprnd),
      .loadOut      (loadOut),
      .oprnd        (oprnd),
      .address_RAM  (address_RAM),
      .pushbuttons  (pushbuttons),
      .data_bus     (data_bus),
      .accu         (accu),
      .FF_out       (FF_out),
      .c_flag       (c_flag),
      .z_flag       (z_flag),
      .bus_conflict (bus_conflict)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to the next rising edge, then move #1 past it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      loadA = 0; loadFlags = 0; cs = 0; we = 0; eoALU = 0;
      oeIn = 0; oeOprnd = 0; loadOut = 0; opALU = ALU_PASSB;
   endtask

   // Load accu/flags with an ALU op whose B operand is the immediate.
   task automatic alu_imm(input alu_op_e op, input logic [3:0] val);
      idle();
      opALU = op; oprnd = val; oeOprnd = 1; loadA = 1; loadFlags = 1;
      step();
   endtask

   initial begin
      idle();
      reset = 0; oprnd = 4'h9; pushbuttons = 4'h0; address_RAM = 12'h003;

      // Reset with enables active: nothing may load.
      loadA = 1; loadFlags = 1; loadOut = 1; oeOprnd = 1; cs = 1; we = 1;
      step(); step();
      check("rst_accu", {4'h0, accu}, 8'h00);
      check("rst_ffout", {4'h0, FF_out}, 8'h00);
      check("rst_flags", {6'h0, c_flag, z_flag}, 8'h00);
      idle();
      #1;
      check("rst_bus_idle", {4'h0, data_bus}, 8'h00);
      check("rst_no_conflict", {7'h0, bus_conflict}, 8'h00);
      @(negedge clock); reset = 1;
      step();

      // Immediate load.
      idle(); opALU = ALU_PASSB; oprnd = 4'h9; oeOprnd = 1; loadA = 1; loadFlags = 1;
      #1 check("imm_bus_comb", {4'h0, data_bus}, 8'h09);
      step();
      check("imm_load", {accu, 2'b0, c_flag, z_flag}, 8'h90);

      // Arithmetic chain; packed as {accu, 00, c, z}.
      alu_imm(ALU_ADD, 4'h8);
      check("add_9_8", {accu, 2'b0, c_flag, z_flag}, 8'h12);
      alu_imm(ALU_SUB, 4'h1);
      check("sub_1_1", {accu, 2'b0, c_flag, z_flag}, 8'h03);
      alu_imm(ALU_SUB, 4'h1);
      check("sub_0_1", {accu, 2'b0, c_flag, z_flag}, 8'hF0);

      // Store accu=5 to addr 3 while loading NOT_A in the same cycle.
      alu_imm(ALU_PASSB, 4'h5);
      idle(); eoALU = 1; cs = 1; we = 1; address_RAM = 12'h003;
      loadA = 1; opALU = ALU_NOTA;
      #1 check("store_bus", {4'h0, data_bus}, 8'h05);
      step();
      check("store_loada", {4'h0, accu}, 8'h0A);

      // Aliased read and output latch.
      idle(); cs = 1; we = 0; address_RAM = 12'h103; loadOut = 1;
      #1 check("ram_read_alias", {4'h0, data_bus}, 8'h05);
      step();
      check("ffout_load", {4'h0, FF_out}, 8'h05);

      // Logic ops from accu=A: carry must stay 0 even where the sum carries.
      alu_imm(ALU_AND, 4'h6);
      check("and_A_6", {accu, 2'b0, c_flag, z_flag}, 8'h20);
      alu_imm(ALU_OR, 4'h5);
      check("or_2_5", {accu, 2'b0, c_flag, z_flag}, 8'h70);
      alu_imm(ALU_XOR, 4'h7);
      check("xor_7_7", {accu, 2'b0, c_flag, z_flag}, 8'h01);
      alu_imm(ALU_NAND, 4'hF);
      check("nand_0_F", {accu, 2'b0, c_flag, z_flag}, 8'hF0);

      // Synchronizer: two edges from pushbuttons to bus.
      idle(); oeIn = 1; pushbuttons = 4'hA;
      #1 check("sync_edge0", {4'h0, data_bus}, 8'h00);
      step();
      check("sync_edge1", {4'h0, data_bus}, 8'h00);
      step();
      check("sync_edge2", {4'h0, data_bus}, 8'h0A);

      // Conflict: oeIn wins over oeOprnd.
      pushbuttons = 4'h3;
      step(); step();
      oeOprnd = 1; oprnd = 4'h7;
      #1 check("conflict_flag", {7'h0, bus_conflict}, 8'h01);
      check("conflict_bus", {4'h0, data_bus}, 8'h03);
      // eoALU outranks everything (accu=F).
      eoALU = 1; cs = 1; we = 0;
      #1 check("prio_accu", {4'h0, data_bus}, 8'h0F);
      idle(); oeOprnd = 1; oprnd = 4'h7;
      #1 check("single_no_conflict", {7'h0, bus_conflict}, 8'h00);

      // Mid-cycle reset with loadA and a pending RAM write of 7 to addr 3.
      idle(); opALU = ALU_PASSB; oeOprnd = 1; oprnd = 4'h7; loadA = 1;
      cs = 1; we = 1; address_RAM = 12'h003;
      #1 reset = 0;
      #1 check("midrst_accu_now", {4'h0, accu}, 8'h00);
      step();
      check("midrst_accu_edge", {4'h0, accu}, 8'h00);
      idle(); reset = 1;
      cs = 1; we = 0; address_RAM = 12'h003;
      #1 check("midrst_ram_kept", {4'h0, data_bus}, 8'h05);

      // First edge after release may load.
      idle(); opALU = ALU_PASSB; oeOprnd = 1; oprnd = 4'h6; loadA = 1;
      step();
      check("release_load", {4'h0, accu}, 8'h06);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_execute_unit
